// File: rtl/acq_seq_pkg.sv
// Shared FSM state encoding, event indices and output defaults for the acquisition sequencer.
package acq_seq_pkg;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RUN     = 2'd1;
  localparam logic [1:0] ST_WAIT_MB = 2'd2;

  localparam int EV_AGC = 0;
  localparam int EV_LD  = 1;
  localparam int EV_EN  = 2;
  localparam int EV_DIS = 3;
  localparam int NUM_EV = 4;

  localparam logic [15:0] AGC_DEFAULT      = 16'h2AAA;
  localparam logic [9:0]  ADC_CTRL_DEFAULT = 10'b0000100100;
endpackage

// File: rtl/acq_seq_event.sv
// One timing event: compares the sequence counter with its event time and emits a registered 1-cycle pulse.
module acq_seq_event #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             i_arm,
  input  logic             i_kill,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_time,
  output logic             o_pulse
);
  logic r_pulse;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) r_pulse <= 1'b0;
    else      r_pulse <= i_arm && !i_kill && (i_cnt == i_time);
  end

  assign o_pulse = r_pulse;
endmodule

// File: rtl/acq_sequencer.sv
// Programmable acquisition sequencer driving AGC load, ADC control-word load and ADC enable.
// Optional feature: define ACQ_SEQ_MBUSY_GATE_EN to hold the enable event until masked adc_mbusy clears.
module acq_sequencer
  import acq_seq_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 32,
  parameter int AGC_W  = 12,
  parameter int CTRL_W = 10
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     periodic,
  input  logic [NUM_CH-1:0]        ch_mask,
  input  logic [CNT_W-1:0]         period,
  input  logic [CNT_W-1:0]         t_agc,
  input  logic [CNT_W-1:0]         t_ld,
  input  logic [CNT_W-1:0]         t_en,
  input  logic [CNT_W-1:0]         t_dis,
  input  logic [AGC_W-1:0]         agc_word,
  input  logic [NUM_CH*CTRL_W-1:0] ctrl_words,
  input  logic [NUM_CH-1:0]        adc_mbusy,
  output logic [AGC_W-1:0]         agc_data,
  output logic                     agc_load,
  output logic [NUM_CH*CTRL_W-1:0] adc_ctrlword,
  output logic [NUM_CH-1:0]        adc_ldctrl,
  output logic [NUM_CH-1:0]        adc_enable,
  output logic                     busy,
  output logic                     cfg_err,
  output logic [15:0]              frame_cnt
);
  localparam logic [AGC_W-1:0]         AGC_DEF  = AGC_W'(AGC_DEFAULT);
  localparam logic [NUM_CH*CTRL_W-1:0] CTRL_DEF = {NUM_CH{CTRL_W'(ADC_CTRL_DEFAULT)}};

  logic [1:0]                r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [15:0]               r_frame;
  logic                      r_cfg_err;
  logic [CNT_W-1:0]          r_period;
  logic [CNT_W-1:0]          r_time [NUM_EV];
  logic                      r_periodic;
  logic [NUM_CH-1:0]         r_mask;
  logic [AGC_W-1:0]          r_agc_sh;
  logic [NUM_CH*CTRL_W-1:0]  r_ctrl_sh;
  logic [AGC_W-1:0]          r_agc_hold;
  logic [NUM_CH*CTRL_W-1:0]  r_ctrl_hold;
  logic [NUM_CH-1:0]         r_en_lvl;

  logic                      w_run;
  logic                      w_accept;
  logic                      w_adv;
  logic                      w_last;
  logic                      w_oneshot_end;
  logic                      w_wait_enter;
  logic                      w_arm_en;
  logic [NUM_EV-1:0]         w_arm;
  logic [NUM_EV-1:0]         w_kill;
  logic [NUM_EV-1:0]         w_pulse;
  logic [NUM_CH-1:0]         w_enable;

  assign w_run    = (r_state == ST_RUN);
  assign w_accept = !stop && (r_state == ST_IDLE) && start && (period >= CNT_W'(2));
  assign w_last   = (r_cnt == r_period - CNT_W'(1));

`ifdef ACQ_SEQ_MBUSY_GATE_EN
  logic w_mb_busy;
  assign w_mb_busy    = |(adc_mbusy & r_mask);
  assign w_wait_enter = w_run && (r_cnt == r_time[EV_EN]) && w_mb_busy;
  assign w_adv        = (w_run && !w_wait_enter) || ((r_state == ST_WAIT_MB) && !w_mb_busy);
  // The counter stays frozen on t_en while waiting, so the enable comparator re-hits on release.
  assign w_arm_en     = (w_run || (r_state == ST_WAIT_MB)) && !w_mb_busy;
`else
  logic w_unused_mbusy;
  assign w_unused_mbusy = |adc_mbusy;
  assign w_wait_enter   = 1'b0;
  assign w_adv          = w_run;
  assign w_arm_en       = w_run;
`endif

  assign w_oneshot_end = w_adv && w_last && !r_periodic && !stop;

  // An enable falling on the last cycle of a one-shot run must not leak past the end.
  assign w_arm  = {w_run, w_arm_en, w_run, w_run};
  assign w_kill = {stop, stop || w_oneshot_end, stop, stop};

  for (genvar gi = 0; gi < NUM_EV; gi++) begin : g_ev
    acq_seq_event #(.CNT_W(CNT_W)) u_ev (
      .clk     (clk),
      .arst    (arst),
      .i_arm   (w_arm[gi]),
      .i_kill  (w_kill[gi]),
      .i_cnt   (r_cnt),
      .i_time  (r_time[gi]),
      .o_pulse (w_pulse[gi])
    );
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_frame   <= '0;
      r_cfg_err <= 1'b0;
    end else if (stop) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_accept) begin
        r_state   <= ST_RUN;
        r_cnt     <= '0;
        r_frame   <= '0;
        r_cfg_err <= 1'b0;
      end else if (start) begin
        r_cfg_err <= 1'b1;
      end
    end else if (w_wait_enter) begin
      r_state <= ST_WAIT_MB;
    end else if (w_adv) begin
      if (w_last) begin
        r_frame <= r_frame + 16'd1;
        r_cnt   <= '0;
        r_state <= r_periodic ? ST_RUN : ST_IDLE;
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_state <= ST_RUN;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_period   <= '0;
      r_periodic <= 1'b0;
      r_mask     <= '0;
      r_agc_sh   <= AGC_DEF;
      r_ctrl_sh  <= CTRL_DEF;
      for (int i = 0; i < NUM_EV; i++) r_time[i] <= '0;
    end else if (w_accept) begin
      r_period       <= period;
      r_periodic     <= periodic;
      r_mask         <= ch_mask;
      r_agc_sh       <= agc_word;
      r_ctrl_sh      <= ctrl_words;
      r_time[EV_AGC] <= t_agc;
      r_time[EV_LD]  <= t_ld;
      r_time[EV_EN]  <= t_en;
      r_time[EV_DIS] <= t_dis;
    end
  end

  // Data outputs switch to the shadowed word in the same cycle as their load pulse, then hold.
  assign agc_load     = w_pulse[EV_AGC];
  assign agc_data     = w_pulse[EV_AGC] ? r_agc_sh : r_agc_hold;
  assign adc_ldctrl   = {NUM_CH{w_pulse[EV_LD]}} & r_mask;
  assign adc_ctrlword = w_pulse[EV_LD] ? r_ctrl_sh : r_ctrl_hold;
  assign w_enable     = (r_en_lvl | ({NUM_CH{w_pulse[EV_EN]}} & r_mask)) & ~{NUM_CH{w_pulse[EV_DIS]}};
  assign adc_enable   = w_enable;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_agc_hold  <= AGC_DEF;
      r_ctrl_hold <= CTRL_DEF;
      r_en_lvl    <= '0;
    end else begin
      r_agc_hold  <= agc_data;
      r_ctrl_hold <= adc_ctrlword;
      r_en_lvl    <= (stop || w_oneshot_end) ? '0 : w_enable;
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign cfg_err   = r_cfg_err;
  assign frame_cnt = r_frame;
endmodule

// File: tb/tb_acq_sequencer.sv
// Self-checking bench for acq_sequencer: directed scenarios plus randomized runs against a cycle-level behavioural model.
module tb_acq_sequencer;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 32;
  localparam int AGC_W  = 12;
  localparam int CTRL_W = 10;
  localparam int CW     = NUM_CH * CTRL_W;
  localparam logic [AGC_W-1:0] AGC_RST  = 12'hAAA;
  localparam logic [CW-1:0]    CTRL_RST = {2{10'b0000100100}};
`ifdef ACQ_SEQ_MBUSY_GATE_EN
  localparam bit GATE = 1'b1;
`else
  localparam bit GATE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              arst, start, stop, periodic;
  logic [NUM_CH-1:0] ch_mask, adc_mbusy;
  logic [CNT_W-1:0]  period, t_agc, t_ld, t_en, t_dis;
  logic [AGC_W-1:0]  agc_word;
  logic [CW-1:0]     ctrl_words;
  logic [AGC_W-1:0]  agc_data;
  logic              agc_load, busy, cfg_err;
  logic [CW-1:0]     adc_ctrlword;
  logic [NUM_CH-1:0] adc_ldctrl, adc_enable;
  logic [15:0]       frame_cnt;

  acq_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .AGC_W(AGC_W), .CTRL_W(CTRL_W)) dut (
    .clk(clk), .arst(arst), .start(start), .stop(stop), .periodic(periodic),
    .ch_mask(ch_mask), .period(period), .t_agc(t_agc), .t_ld(t_ld), .t_en(t_en), .t_dis(t_dis),
    .agc_word(agc_word), .ctrl_words(ctrl_words), .adc_mbusy(adc_mbusy),
    .agc_data(agc_data), .agc_load(agc_load), .adc_ctrlword(adc_ctrlword), .adc_ldctrl(adc_ldctrl),
    .adc_enable(adc_enable), .busy(busy), .cfg_err(cfg_err), .frame_cnt(frame_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: expected outputs plus the configuration captured at start.
  bit                m_run, m_wait, m_cfg_err, m_agc_load;
  int unsigned       m_cnt;
  logic [15:0]       m_frame;
  logic [NUM_CH-1:0] m_en, m_ld;
  logic [AGC_W-1:0]  m_agc_data;
  logic [CW-1:0]     m_ctrl;
  int unsigned       s_period, s_agc, s_ld, s_en, s_dis;
  bit                s_periodic;
  logic [NUM_CH-1:0] s_mask;
  logic [AGC_W-1:0]  s_word;
  logic [CW-1:0]     s_ctrl;
  logic [NUM_CH-1:0] acc_en, acc_ld;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_wait = 0; m_cfg_err = 0; m_agc_load = 0;
    m_cnt = 0; m_frame = '0; m_en = '0; m_ld = '0;
    m_agc_data = AGC_RST; m_ctrl = CTRL_RST;
  endtask

  task automatic model_step();
    logic [NUM_CH-1:0] nen;
    bit mb;
    if (arst) begin model_reset(); return; end
    m_agc_load = 0; m_ld = '0;
    if (stop) begin m_run = 0; m_wait = 0; m_cnt = 0; m_en = '0; return; end
    if (!m_run) begin
      if (start) begin
        if (period >= 2) begin
          s_period = period; s_agc = t_agc; s_ld = t_ld; s_en = t_en; s_dis = t_dis;
          s_periodic = periodic; s_mask = ch_mask; s_word = agc_word; s_ctrl = ctrl_words;
          m_cnt = 0; m_frame = '0; m_cfg_err = 0; m_run = 1;
        end else begin
          m_cfg_err = 1;
        end
      end
      return;
    end
    mb = |(adc_mbusy & s_mask);
    if (m_wait) begin
      if (mb) return;
      m_wait = 0;
      m_en = m_en | s_mask;
    end else begin
      if (m_cnt == s_agc) begin m_agc_data = s_word; m_agc_load = 1; end
      if (m_cnt == s_ld) begin m_ctrl = s_ctrl; m_ld = s_mask; end
      nen = m_en;
      if (m_cnt == s_en) begin
        if (GATE && mb) m_wait = 1;
        else nen = nen | s_mask;
      end
      if (m_cnt == s_dis) nen = '0;
      m_en = nen;
      if (m_wait) return;
    end
    if (m_cnt == s_period - 1) begin
      m_frame = m_frame + 16'd1;
      m_cnt = 0;
      if (!s_periodic) begin m_run = 0; m_en = '0; end
    end else begin
      m_cnt++;
    end
  endtask

  task automatic compare_all();
    check_eq("agc_load", 64'(agc_load), 64'(m_agc_load));
    check_eq("agc_data", 64'(agc_data), 64'(m_agc_data));
    check_eq("ldctrl",   64'(adc_ldctrl), 64'(m_ld));
    check_eq("ctrlword", 64'(adc_ctrlword), 64'(m_ctrl));
    check_eq("enable",   64'(adc_enable), 64'(m_en));
    check_eq("busy",     64'(busy), 64'(m_run));
    check_eq("cfg_err",  64'(cfg_err), 64'(m_cfg_err));
    check_eq("frame",    64'(frame_cnt), 64'(m_frame));
    acc_en = acc_en | adc_enable;
    acc_ld = acc_ld | adc_ldctrl;
  endtask

  task automatic step(input bit s_start, input bit s_stop);
    start = s_start; stop = s_stop;
    adc_mbusy = NUM_CH'($urandom);
    @(posedge clk); model_step();
    @(negedge clk); compare_all();
    start = 0; stop = 0;
  endtask

  task automatic set_cfg(input int per, input int ta, input int tl, input int te, input int td,
                         input bit perd, input logic [NUM_CH-1:0] mask);
    period = CNT_W'(per); t_agc = CNT_W'(ta); t_ld = CNT_W'(tl); t_en = CNT_W'(te); t_dis = CNT_W'(td);
    periodic = perd; ch_mask = mask; agc_word = AGC_W'($urandom); ctrl_words = CW'($urandom);
  endtask

  task automatic rand_cfg();
    int p;
    p = $urandom_range(0, 16);
    set_cfg(p, $urandom_range(0, p + 2), $urandom_range(0, p + 2), $urandom_range(0, p + 2),
            $urandom_range(0, p + 2), 1'($urandom), NUM_CH'($urandom));
  endtask

  task automatic run(input int n, input bit rnd);
    for (int i = 0; i < n; i++) begin
      bit s, p;
      s = 0; p = 0;
      if (rnd) begin
        if ($urandom_range(0, 7) == 0) rand_cfg();
        s = ($urandom_range(0, 15) == 0);
        p = ($urandom_range(0, 39) == 0);
      end
      step(s, p);
    end
  endtask

  initial begin
    arst = 1; start = 0; stop = 0; adc_mbusy = '0;
    acc_en = '0; acc_ld = '0;
    set_cfg(0, 0, 0, 0, 0, 0, '0);
    model_reset();
    step(0, 0); step(0, 0);
    check_eq("rst_agc_data", 64'(agc_data), 64'(AGC_RST));
    check_eq("rst_ctrlword", 64'(adc_ctrlword), 64'(CTRL_RST));
    arst = 0;
    $display("txn reset: agc_data=%0h ctrlword=%0h", agc_data, adc_ctrlword);

    set_cfg(100, 5, 10, 20, 80, 0, 2'b11);
    step(1, 0);
    run(105, 0);
    check_eq("t2_frame", 64'(frame_cnt), 64'd1);
    check_eq("t2_busy", 64'(busy), 64'd0);
    $display("txn one-shot period=100: frame_cnt=%0d", frame_cnt);

    set_cfg(10, 1, 3, 2, 50, 1, 2'b11);
    step(1, 0);
    run(35, 0);
    step(0, 1);
    check_eq("t3_frame", 64'(frame_cnt), 64'd3);
    check_eq("t3_enable", 64'(adc_enable), 64'd0);
    check_eq("t3_busy", 64'(busy), 64'd0);
    $display("txn periodic stop: frame_cnt=%0d", frame_cnt);

    set_cfg(1, 0, 0, 0, 0, 0, 2'b11);
    step(1, 0);
    check_eq("t4_cfg_err", 64'(cfg_err), 64'd1);
    check_eq("t4_busy", 64'(busy), 64'd0);
    run(3, 0);
    set_cfg(10, 2, 3, 4, 6, 0, 2'b01);
    step(1, 0);
    check_eq("t4_cfg_clr", 64'(cfg_err), 64'd0);
    run(12, 0);
    $display("txn cfg_err: cleared=%0b", !cfg_err);

    acc_en = '0; acc_ld = '0;
    set_cfg(8, 0, 3, 4, 4, 0, 2'b10);
    step(1, 0);
    run(10, 0);
    check_eq("t5_en_never", 64'(acc_en), 64'd0);
    check_eq("t5_ld_bits", 64'(acc_ld), 64'(2'b10));
    $display("txn mask/en==dis: enable_seen=%0b ld_seen=%0b", acc_en, acc_ld);

    set_cfg(6, 1, 2, 3, 5, 1, 2'b11);
    step(1, 0);
    run(9, 0);
    #2 arst = 1;
    #1 model_reset();
    compare_all();
    step(0, 0);
    arst = 0;
    $display("txn async reset mid-run: busy=%0b enable=%0b", busy, adc_enable);

    for (int k = 0; k < 40; k++) begin
      rand_cfg();
      step(1, 0);
      run($urandom_range(5, 60), 1);
      if ($urandom_range(0, 2) == 0) step(0, 1);
      $display("txn random %0d: period=%0d periodic=%0b frame_cnt=%0d", k, period, periodic, frame_cnt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
